// File: rtl/jit_token_seq.sv
// jit_token_seq: command-driven launcher for one ap_ctrl_hs accelerator.
//
// Command words are accepted only in FETCH, so the argument registers stay
// stable while the accelerator runs. Each Go command runs the accelerator
// one or more times. A one-cycle done pulse marks the end of the final run.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | idle; accept and decode command words
// WAIT_IDLE | run pending; wait for the accelerator to report ap_idle
// START     | ap_start asserted; wait for ap_ready or ap_done
// RUN       | inputs consumed; wait for ap_done
//
// Ports:
//   ap_clk, ap_rst_n      clock and asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd[31:28] is the opcode,
//                         cmd[23:20] the argument index, cmd[15:0] the payload
//   ap_start              accelerator start (decoded from the state register)
//   ap_ready/ap_idle/ap_done  accelerator status inputs
//   args                  flattened arguments; arg k at [k*ARG_W +: ARG_W]
//   busy                  high in any state other than FETCH
//   done                  one-cycle pulse after the final run of a Go
//   err                   sticky error (bad opcode or bad index); cleared by Clear
//   runs_left             remaining runs including the current one
`timescale 1ns/1ps
module jit_token_seq #(
  parameter int NARGS = 3,
  parameter int ARG_W = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [31:0]            cmd,
  output logic                   ap_start,
  input  logic                   ap_ready,
  input  logic                   ap_idle,
  input  logic                   ap_done,
  output logic [NARGS*ARG_W-1:0] args,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [15:0]            runs_left
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'b0001,
    S_WAIT_IDLE = 4'b0010,
    S_START     = 4'b0100,
    S_RUN       = 4'b1000
  } state_e;

  localparam logic [3:0] OP_GO     = 4'hA;
  localparam logic [3:0] OP_SETARG = 4'hC;
  localparam logic [3:0] OP_CLEAR  = 4'hE;

  state_e                 state_q, state_d;
  logic [NARGS*ARG_W-1:0] args_q, args_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic [15:0]            runs_left_q, runs_left_d;

  logic [3:0] opcode;
  logic [3:0] arg_idx;
  logic       complete;
  logic       unused_cmd_bits;

  assign opcode          = cmd[31:28];
  assign arg_idx         = cmd[23:20];
  assign unused_cmd_bits = ^{cmd[27:24], cmd[19:16]};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_FETCH;
      args_q      <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      runs_left_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      args_q      <= args_d;
      err_q       <= err_d;
      done_q      <= done_d;
      runs_left_q <= runs_left_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    args_d      = args_q;
    err_d       = err_q;
    done_d      = 1'b0;
    runs_left_d = runs_left_q;
    complete    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (cmd_valid) begin
          case (opcode)
            OP_GO: begin
              // A zero count still means one run.
              runs_left_d = (cmd[15:0] == 16'd0) ? 16'd1 : cmd[15:0];
              state_d     = S_WAIT_IDLE;
            end
            OP_SETARG: begin
              if (int'(arg_idx) < NARGS) begin
                for (int k = 0; k < NARGS; k++) begin
                  if (arg_idx == 4'(k)) args_d[k*ARG_W +: ARG_W] = cmd[ARG_W-1:0];
                end
              end else begin
                err_d = 1'b1;
              end
            end
            OP_CLEAR: begin
              args_d = '0;
              err_d  = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_WAIT_IDLE: begin
        if (ap_idle) state_d = S_START;
      end
      S_START: begin
        // A run short enough to finish in the start cycle reports ap_done
        // here, possibly together with ap_ready; treat it as completion.
        if (ap_done)       complete = 1'b1;
        else if (ap_ready) state_d  = S_RUN;
      end
      S_RUN: begin
        if (ap_done) complete = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    if (complete) begin
      if (runs_left_q == 16'd1) begin
        runs_left_d = 16'd0;
        done_d      = 1'b1;
        state_d     = S_FETCH;
      end else begin
        runs_left_d = runs_left_q - 16'd1;
        state_d     = S_WAIT_IDLE;
      end
    end
  end

  assign cmd_ready = (state_q == S_FETCH);
  assign busy      = (state_q != S_FETCH);
  assign ap_start  = (state_q == S_START);
  assign args      = args_q;
  assign err       = err_q;
  assign done      = done_q;
  assign runs_left = runs_left_q;

endmodule
